// File: rtl/rv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv_ctrl_pkg
// Brief    : Shared types and encodings for the multicycle RV32 control path:
//            FSM states, instruction classes, opcodes, immediate-format and
//            PC-source encodings (also used by the immediate generator).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_UPPER  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6
  } cls_t;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  // Immediate-format select
  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_U = 3'b011;
  localparam logic [2:0] c_IMM_J = 3'b100;

  // PC source select
  localparam logic [1:0] c_PC_PLUS4 = 2'b00;
  localparam logic [1:0] c_PC_REL   = 2'b01;
  localparam logic [1:0] c_PC_REG   = 2'b10;

endpackage : rv_ctrl_pkg

`default_nettype wire

// File: rtl/ctrl_decode.sv
//------------------------------------------------------------------------------
// Module   : ctrl_decode
// Brief    : Combinational opcode decoder. Maps instr[6:0] to an instruction
//            class, the immediate format, a hold flag for formats that carry
//            no immediate (R-type) and an illegal-opcode flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_t       o_cls,
  output logic [2:0] o_imm_type,
  output logic       o_imm_hold,
  output logic       o_illegal
);

  // Opcode lookup; anything not listed is illegal
  always_comb begin
    o_cls      = CLS_ALU;
    o_imm_type = c_IMM_I;
    o_imm_hold = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      c_OPC_LUI,
      c_OPC_AUIPC:  begin o_cls = CLS_UPPER;  o_imm_type = c_IMM_U; end
      c_OPC_JAL:    begin o_cls = CLS_JAL;    o_imm_type = c_IMM_J; end
      c_OPC_JALR:   begin o_cls = CLS_JALR;   o_imm_type = c_IMM_I; end
      c_OPC_LOAD:   begin o_cls = CLS_LOAD;   o_imm_type = c_IMM_I; end
      c_OPC_OPIMM:  begin o_cls = CLS_ALU;    o_imm_type = c_IMM_I; end
      c_OPC_STORE:  begin o_cls = CLS_STORE;  o_imm_type = c_IMM_S; end
      c_OPC_BRANCH: begin o_cls = CLS_BRANCH; o_imm_type = c_IMM_B; end
      // R-type has no immediate: the previous format is kept
      c_OPC_OP:     begin o_cls = CLS_ALU;    o_imm_hold = 1'b1;    end
      default:      o_illegal = 1'b1;
    endcase
  end

endmodule : ctrl_decode

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Brief    : Multicycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//            Drives the memory handshake, IR/regfile/PC write strobes, PC
//            source and immediate-format selects, and a sticky trap flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [2:0] imm_type,
  output logic       retire,
  output logic       trap
);

  state_t     r_state;
  cls_t       r_cls;
  logic [2:0] r_imm_type;
  logic       r_trap;

  cls_t       w_cls;
  logic [2:0] w_dec_imm;
  logic       w_dec_hold;
  logic       w_dec_illegal;

  ctrl_decode u_decode (
    .i_opcode   (opcode),
    .o_cls      (w_cls),
    .o_imm_type (w_dec_imm),
    .o_imm_hold (w_dec_hold),
    .o_illegal  (w_dec_illegal)
  );

  // State sequencing; class and immediate format are captured once in DECODE
  // so later states do not depend on the IR staying stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_cls      <= CLS_ALU;
      r_imm_type <= c_IMM_I;
      r_trap     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_dec_illegal) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
            r_cls   <= w_cls;
            if (!w_dec_hold) r_imm_type <= w_dec_imm;
          end
        end
        ST_EXEC: begin
          case (r_cls)
            CLS_BRANCH:          r_state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
            default:             r_state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) r_state <= (r_cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_TRAP;
      endcase
    end
  end

  // Strobes are decoded from the registered state together with mem_ready and
  // br_taken, because they must coincide with the completing handshake and
  // with the branch outcome; rst_n gates them so reset silences the outputs
  // at once and abandons any open request without a strobe.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = c_PC_PLUS4;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXEC: begin
          if (r_cls == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? c_PC_REL : c_PC_PLUS4;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (r_cls == CLS_STORE);
          pc_we   = mem_ready && (r_cls == CLS_STORE);
        end
        ST_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (r_cls == CLS_JAL)       pc_sel = c_PC_REL;
          else if (r_cls == CLS_JALR) pc_sel = c_PC_REG;
          else                        pc_sel = c_PC_PLUS4;
        end
        default: ;
      endcase
    end
    retire = pc_we;
  end

  assign imm_type = r_imm_type;
  assign trap     = r_trap;

endmodule : multicycle_ctrl

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  7  instr[6:0] from the instruction register; valid from DECODE onward.
REQ-004 mem_ready  input  1  memory completes the current request in this cycle.
REQ-005 br_taken  input  1  branch-compare result from the ALU; sampled in EXEC only.
REQ-006 mem_req  output  1  memory request; held high until mem_ready.
REQ-007 mem_we  output  1  request is a write; meaningful only while mem_req=1.
REQ-008 ir_we  output  1  load the instruction register.
REQ-009 reg_we  output  1  register-file write strobe.
REQ-010 pc_we  output  1  PC update strobe; exactly one pulse per retired instruction.
REQ-011 pc_sel  output  2  PC source: 00 PC+4, 01 PC+imm, 10 rs1+imm.
REQ-012 imm_type  output  3  immediate-format select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-013 retire  output  1  one-cycle pulse coincident with each pc_we.
REQ-014 trap  output  1  illegal opcode detected; sticky until reset.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP, and SHALL enter FETCH on reset.
REQ-016 FETCH: mem_req=1, mem_we=0, and the FSM waits. In the cycle where mem_ready=1, ir_we=1 and the next state is DECODE.
REQ-017 DECODE: imm_type SHALL be registered from opcode as follows.
- LUI 0110111 and AUIPC 0010111 -> 011.
- JAL 1101111 -> 100.
- JALR 1100111, LOAD 0000011 and OP-IMM 0010011 -> 000.
- STORE 0100011 -> 001.
- BRANCH 1100011 -> 010.
- OP 0110011 -> unchanged.
REQ-018 imm_type SHALL hold its value from DECODE until the next DECODE.
REQ-019 Any other opcode in DECODE SHALL cause the transition DECODE -> TRAP and SHALL set trap=1.
REQ-020 EXEC transitions:
- BRANCH -> FETCH, with pc_we=1, pc_sel=01 if br_taken else 00.
- LOAD or STORE -> MEM.
- All other legal opcodes -> WB.
REQ-021 MEM: mem_req=1, and mem_we=1 for STORE only; the FSM waits for mem_ready.
- STORE on mem_ready -> FETCH, with pc_we=1, pc_sel=00.
- LOAD on mem_ready -> WB.
REQ-022 WB: reg_we=1 and pc_we=1 for one cycle, then FETCH.
- pc_sel=01 for JAL, 10 for JALR, 00 otherwise.
REQ-023 All strobes (ir_we, reg_we, pc_we, retire) SHALL be single-cycle and SHALL never be asserted outside the states named above.
REQ-024 Latency with mem_ready tied high SHALL be:
- 3 cycles for BRANCH.
- 4 cycles for OP, OP-IMM, LUI, AUIPC, JAL, JALR and STORE.
- 5 cycles for LOAD.
REQ-025 Each cycle of mem_ready=0 in FETCH or MEM SHALL add exactly one cycle of latency. mem_req SHALL never drop before mem_ready.
REQ-026 TRAP SHALL hold every strobe and mem_req at 0 and trap=1 until rst_n is asserted.
REQ-027 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-028 While rst_n=0, all outputs SHALL be 0, imm_type SHALL be 000 and the state SHALL be FETCH, independent of clk.
REQ-029 The first cycle after rst_n deasserts SHALL drive mem_req=1.
REQ-030 Reset asserted mid-request SHALL abandon the request immediately, with no strobe issued.

Structure
REQ-031 A shared package rv_ctrl_pkg SHALL hold the following:
- The state enum.
- The opcode constants.
- The imm_type encoding, shared with the immediate generator.
- The pc_sel encoding.
REQ-032 A combinational sub-module ctrl_decode SHALL map opcode to a class (branch, load, store, jal, jalr, alu, upper) plus imm_type and illegal. The FSM SHALL remain in multicycle_ctrl.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
- Reset release with mem_ready=1 and opcode 0110011 -> sequence FETCH, DECODE, EXEC, WB; reg_we and pc_we in cycle 4; pc_sel=00.
- LOAD 0000011 with mem_ready low for 2 MEM cycles -> mem_req high for 3 cycles in MEM, mem_we=0; reg_we 7 cycles after FETCH start; imm_type=000.
- STORE 0100011 -> mem_we=1 in MEM; imm_type=001; reg_we never asserted; pc_we in cycle 4.
- BRANCH 1100011 with br_taken=1, then again with br_taken=0 -> pc_we in cycle 3 with pc_sel=01 and 00 respectively; imm_type=010.
- JAL 1101111, then JALR 1100111 -> imm_type 100 and 000 respectively; pc_sel 01 and 10 in WB.
- Opcode 1111111 -> trap=1 the cycle after DECODE; no further mem_req; rst_n pulse clears trap and restarts FETCH.
